// File: rtl/debug_slave_cmd_queue_pkg.sv
// Shared definitions for the debug slave command queue.
//   SR_W_DEF / IR_W_DEF : default data-register and instruction widths
//   cmd_entry_t         : one queued command, {ir, data}
//   chan_e              : command channel index, keyed by instruction value
package debug_slave_cmd_queue_pkg;

    localparam int SR_W_DEF = 38;
    localparam int IR_W_DEF = 2;

    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [SR_W_DEF-1:0] data;
    } cmd_entry_t;

    typedef enum logic [IR_W_DEF-1:0] {
        OCIMEM_A    = 2'd0,
        TRACEMEM_A  = 2'd1,
        BREAK_A     = 2'd2,
        TRACECTRL_A = 2'd3
    } chan_e;

endpackage

// File: rtl/debug_slave_cmd_queue_sync.sv
// Level synchronizer with rising-edge detection.
//   clk, reset_n : destination clock, async active-low reset
//   din          : asynchronous level input
//   rise         : one-cycle pulse on a synchronized 0->1 transition
// The detector arms only after a genuinely low level has travelled through
// the chain since reset, so a level that is already high at reset release
// never produces a pulse.
module debug_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   edge_q;
    logic                   armed_q;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            fill_q  <= '0;
            edge_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            // fill_q marks when sync_lvl carries a real sample, not a reset value
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            edge_q <= sync_lvl;
            if (fill_q[SYNC_STAGES-1] && !sync_lvl)
                armed_q <= 1'b1;
        end
    end

    assign rise = sync_lvl & ~edge_q & armed_q;

endmodule

// File: rtl/debug_slave_cmd_queue.sv
// Virtual-JTAG command capture queue.
//   clk, reset_n      : system clock, async active-low reset
//   vs_e1dr           : exit1-DR level from the TCK domain (asynchronous)
//   ir_in, sr         : instruction and shifted data, stable while vs_e1dr high
//   cmd_ready         : consumer ready; pops the head when cmd_valid is high
//   clr_overflow      : clears the sticky overflow flag
//   cmd_valid         : queue not empty
//   jdo, cmd_ir       : head entry data and instruction
//   take_action       : one-hot channel pulse, one cycle after each pop
//   level             : occupancy, 0..DEPTH
//   overflow          : sticky, set when a capture is dropped on a full queue
module debug_slave_cmd_queue
    import debug_slave_cmd_queue_pkg::*;
#(
    parameter int SR_W        = SR_W_DEF,
    parameter int IR_W        = IR_W_DEF,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     vs_e1dr,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [SR_W-1:0]          sr,
    input  logic                     cmd_ready,
    input  logic                     clr_overflow,
    output logic                     cmd_valid,
    output logic [SR_W-1:0]          jdo,
    output logic [IR_W-1:0]          cmd_ir,
    output logic [(2**IR_W)-1:0]     take_action,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int NCH = 2**IR_W;
    localparam int EW  = IR_W + SR_W;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic              strobe;
    logic [EW-1:0]     stage_q;
    logic              stage_v;
    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [EW-1:0]     head;
    logic              pop;
    logic              push;
    logic              drop;

    debug_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (vs_e1dr),
        .rise    (strobe)
    );

    // Stage register: holds the captured command for one cycle before the
    // queue decides to accept or drop it.
    always_ff @(posedge clk) begin
        if (strobe)
            stage_q <= {ir_in, sr};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stage_v <= 1'b0;
        else
            stage_v <= strobe;
    end

    assign cmd_valid = (level != '0);
    assign head      = mem[rptr];
    assign cmd_ir    = head[EW-1:SR_W];
    assign jdo       = head[SR_W-1:0];

    // A pop on a full queue frees the slot before the staged capture is judged.
    always_comb begin
        pop  = cmd_valid & cmd_ready;
        push = 1'b0;
        drop = 1'b0;
        if (stage_v) begin
            if (level != FULL_LVL || pop)
                push = 1'b1;
            else
                drop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= stage_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr        <= '0;
            rptr        <= '0;
            level       <= '0;
            overflow    <= 1'b0;
            take_action <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);

            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            if (drop)
                overflow <= 1'b1;
            else if (clr_overflow)
                overflow <= 1'b0;

            take_action <= pop ? (NCH'(1) << cmd_ir) : '0;
        end
    end

endmodule

// File: doc/debug_slave_cmd_queue.md
DEBUG_SLAVE_CMD_QUEUE -- requirements
Module: debug_slave_cmd_queue

Interface
REQ-001 The parameter SR_W SHALL default to 38 and SHALL set the JTAG data-register (shift register) width.
REQ-002 The parameter IR_W SHALL default to 2 and SHALL set the virtual-JTAG instruction width; the number of command channels SHALL be 2**IR_W.
REQ-003 The parameter DEPTH SHALL default to 4 and SHALL set the command-queue depth; legal values SHALL be powers of two from 2 to 16.
REQ-004 The parameter SYNC_STAGES SHALL default to 2 and SHALL set the synchronizer length; the minimum legal value SHALL be 2.
REQ-005 The design SHALL have one clock, clk; reset_n SHALL be asynchronous and active-low.
REQ-006 Port clk: input, 1 bit, system clock.
REQ-007 Port reset_n: input, 1 bit, asynchronous active-low reset.
REQ-008 Port vs_e1dr: input, 1 bit, exit1-DR level from the TCK domain; the block SHALL treat it as asynchronous.
REQ-009 Port ir_in: input, IR_W bits, instruction; it SHALL be quasi-static while vs_e1dr is high.
REQ-010 Port sr: input, SR_W bits, shifted data; it SHALL be quasi-static while vs_e1dr is high.
REQ-011 Port cmd_ready: input, 1 bit, consumer ready.
REQ-012 Port clr_overflow: input, 1 bit, synchronous clear of overflow.
REQ-013 Port cmd_valid: output, 1 bit, queue head valid.
REQ-014 Port jdo: output, SR_W bits, head data.
REQ-015 Port cmd_ir: output, IR_W bits, head instruction.
REQ-016 Port take_action: output, 2**IR_W bits, one-hot pulse on command acceptance.
REQ-017 Port level: output, $clog2(DEPTH)+1 bits, occupancy.
REQ-018 Port overflow: output, 1 bit, sticky flag for a dropped command.

Function
REQ-019 vs_e1dr SHALL pass through a SYNC_STAGES flip-flop chain followed by one edge-detect register; only a synchronized rising edge SHALL generate a capture strobe.
REQ-020 On a capture strobe, the block SHALL sample {ir_in, sr} from the stage register in the same cycle the strobe is generated and SHALL enqueue it when level < DEPTH.
REQ-021 A capture strobe with level == DEPTH SHALL drop the command, SHALL set overflow, and SHALL leave the queue unchanged.
REQ-022 cmd_valid SHALL equal (level != 0); jdo and cmd_ir SHALL present the head entry combinationally from the registered array.
REQ-023 A handshake SHALL occur when cmd_valid and cmd_ready are both high; it SHALL pop the head.
REQ-024 In the cycle after a handshake, take_action[cmd_ir] SHALL be high for exactly one cycle; all other take_action bits SHALL be low.
REQ-025 Enqueue and pop in the same cycle SHALL leave level unchanged; when full, a simultaneous pop SHALL free the slot first, so the capture SHALL be accepted with no overflow.
REQ-026 Capture-to-cmd_valid latency SHALL be SYNC_STAGES+2 clk cycles from the vs_e1dr rise, when the queue is empty.
REQ-027 The read and write pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap modulo DEPTH.
REQ-028 level SHALL never exceed DEPTH and SHALL never underflow; cmd_ready while empty SHALL be ignored.
REQ-029 clr_overflow SHALL clear overflow on the next edge unless a drop occurs in the same cycle, in which case set SHALL win.
REQ-030 A vs_e1dr pulse held high for many cycles SHALL produce exactly one capture.

Reset
REQ-031 While reset_n is low, all synchronizer stages, the edge register, the pointers, level, overflow and take_action SHALL be 0, and cmd_valid SHALL be 0.
REQ-032 Queue storage SHALL NOT require reset; jdo and cmd_ir SHALL be don't-care while cmd_valid is 0.
REQ-033 Reset asserted mid-operation SHALL discard all queued commands; a vs_e1dr level that is high at deassertion SHALL NOT create a capture until vs_e1dr falls and rises again.

Structure
REQ-034 A shared package SHALL hold the default SR_W/IR_W constants, the cmd_entry typedef ({ir, data}), and the channel-index constants (BREAK_A, OCIMEM_A, ... mapped to ir values).
REQ-035 The synchronizer SHALL be a separate sub-module, debug_sync_edge (parameter SYNC_STAGES; outputs rise pulse), reusable for vs_uir.

Verification
REQ-036 Scenario: reset, then vs_e1dr high for 5 clk with ir_in=2'b01 and sr=38'h2A_DEAD_BEEF, cmd_ready=1 -> cmd_valid rises at cycle 4, jdo=38'h2A_DEAD_BEEF, take_action=4'b0010 for one cycle, exactly once.
REQ-037 Scenario: cmd_ready=0, five captures with DEPTH=4 -> level=4, overflow=1, and the fifth command is absent when drained.
REQ-038 Scenario: full queue, capture strobe coincident with a handshake -> level stays 4, overflow stays 0, and the new entry is last out.
REQ-039 Scenario: captures with ir 0,1,2,3 drained with cmd_ready toggling 1010 -> take_action sequence 0001, 0010, 0100, 1000, with each pulse one cycle after its handshake.
REQ-040 Scenario: reset asserted with level=3 while vs_e1dr is high, then released -> level=0, cmd_valid=0, and no capture occurs until a fresh vs_e1dr rise.
REQ-041 Scenario: clr_overflow and a drop in the same cycle -> overflow remains 1.
